// File: rtl/main_memory_responder_pkg.sv
// Shared memory-system definitions: word width, cache line length and the
// responder state encoding used by the arbiter, caches and main memory.
package main_memory_responder_pkg;

  localparam int WORD_W        = 16;
  localparam int MEM_BURST_LEN = 4;

  typedef logic [WORD_W-1:0] memWord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } memState_t;

  // Width of a counter that must reach burstLen-1; kept at least one bit so
  // a single-word line still has a legal counter.
  function automatic int lineOffsetBits(input int burstLen);
    return (burstLen > 1) ? $clog2(burstLen) : 1;
  endfunction

endpackage

// File: rtl/main_memory_responder_mem_array.sv
// Backing store: single address port, synchronous write, asynchronous read.
// Contents are deliberately not reset so data survives a responder reset.
module mem_array
  import main_memory_responder_pkg::*;
#(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  memWord_t                 wData,
  output memWord_t                 rData
);

  memWord_t mem [WORDS];

  // Commit a write word at the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wData;
    end
  end

  assign rData = mem[addr];

endmodule

// File: rtl/main_memory_responder.sv
// Main memory responder: accepts one read or write request at a time, waits
// LATENCY cycles, then either streams a line-aligned burst or commits a write.
module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int BURST_LEN = MEM_BURST_LEN,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memoryEnable,
  input  logic              memWrite,
  input  logic [WORD_W-1:0] addrToMem,
  input  logic [WORD_W-1:0] dataToMem,
  output logic              memBusy,
  output logic [WORD_W-1:0] dataFromMem,
  output logic              memDataValid,
  output logic              memBurstLast,
  output logic              memWriteDone
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = $clog2(LATENCY);
  localparam int BW = lineOffsetBits(BURST_LEN);

  // WAIT covers cycles T+1..T+LATENCY-1 for a read; a write also spends
  // cycle T+LATENCY in WAIT to raise its done pulse.
  localparam logic [LW-1:0] LAT_COMMIT = LW'(LATENCY - 2);
  localparam logic [LW-1:0] LAT_LAST   = LW'(LATENCY - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [AW-1:0] LINE_MASK  = ~AW'(BURST_LEN - 1);

  memState_t       state;
  memState_t       nextState;
  logic [LW-1:0]   latCnt;
  logic [BW-1:0]   burstCnt;
  logic [AW-1:0]   capIdx;
  memWord_t        capData;
  logic            capWrite;
  logic            memWe;
  logic [AW-1:0]   memAddr;
  logic [AW-1:0]   lineBase;
  memWord_t        memRData;

  assign lineBase = capIdx & LINE_MASK;

  // Upper address bits are intentionally discarded (storage wraps).
  if (AW < WORD_W) begin : gAddrHi
    logic unusedAddrHi;
    assign unusedAddrHi = ^addrToMem[WORD_W-1:AW];
  end

  mem_array #(
    .WORDS (MEM_WORDS)
  ) uMem (
    .clk   (clk),
    .we    (memWe),
    .addr  (memAddr),
    .wData (capData),
    .rData (memRData)
  );

  // State register and the latency/burst counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      latCnt   <= '0;
      burstCnt <= '0;
    end else begin
      state    <= nextState;
      latCnt   <= (state == WAIT  && nextState == WAIT)  ? latCnt + LW'(1)   : '0;
      burstCnt <= (state == BURST && nextState == BURST) ? burstCnt + BW'(1) : '0;
    end
  end

  // Request capture on acceptance; holds steady for the whole transaction.
  always_ff @(posedge clk) begin
    if (state == IDLE && memoryEnable) begin
      capIdx   <= addrToMem[AW-1:0];
      capData  <= dataToMem;
      capWrite <= memWrite;
    end
  end

  // Next-state decode, storage control and response outputs.
  always_comb begin
    nextState    = state;
    memBusy      = 1'b0;
    memDataValid = 1'b0;
    memBurstLast = 1'b0;
    memWriteDone = 1'b0;
    memWe        = 1'b0;
    memAddr      = (state == BURST) ? lineBase + AW'(burstCnt) : capIdx;
    unique case (state)
      IDLE: begin
        if (memoryEnable) nextState = WAIT;
      end
      WAIT: begin
        memBusy = 1'b1;
        if (capWrite) begin
          // Reset on the commit edge wins, so an aborted write never lands.
          memWe = (latCnt == LAT_COMMIT) && !rst;
          if (latCnt == LAT_LAST) begin
            memWriteDone = 1'b1;
            nextState    = IDLE;
          end
        end else if (latCnt == LAT_COMMIT) begin
          nextState = BURST;
        end
      end
      BURST: begin
        memBusy      = 1'b1;
        memDataValid = 1'b1;
        if (burstCnt == BURST_LAST) begin
          memBurstLast = 1'b1;
          nextState    = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    dataFromMem = memDataValid ? memRData : '0;
  end

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

  localparam int L  = 4;
  localparam int BL = 4;
  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memoryEnable = 1'b0;
  logic        memWrite = 1'b0;
  logic [15:0] addrToMem = '0;
  logic [15:0] dataToMem = '0;
  logic        memBusy;
  logic [15:0] dataFromMem;
  logic        memDataValid;
  logic        memBurstLast;
  logic        memWriteDone;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit checkOn = 1'b0;

  main_memory_responder #(
    .LATENCY   (L),
    .BURST_LEN (BL),
    .MEM_WORDS (MW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .memoryEnable (memoryEnable),
    .memWrite     (memWrite),
    .addrToMem    (addrToMem),
    .dataToMem    (dataToMem),
    .memBusy      (memBusy),
    .dataFromMem  (dataFromMem),
    .memDataValid (memDataValid),
    .memBurstLast (memBurstLast),
    .memWriteDone (memWriteDone)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, got, exp);
    end
  endtask

  // Transaction-level model: one outstanding request described by its
  // acceptance cycle; expected outputs follow from interval arithmetic.
  logic [15:0] modelMem [MW];
  bit          act = 1'b0;
  bit          actWr;
  int          actT, actEnd, actIdx, actBase;
  logic [15:0] actData;

  always @(negedge clk) begin
    if (checkOn) begin
      automatic logic        eBusy = 1'b0;
      automatic logic        eValid = 1'b0;
      automatic logic        eLast = 1'b0;
      automatic logic        eDone = 1'b0;
      automatic logic [15:0] eData = '0;
      if (act) begin
        eBusy = 1'b1;
        if (actWr) begin
          eDone = (cyc == actT + L);
        end else if (cyc >= actT + L) begin
          automatic int k = cyc - actT - L;
          eValid = 1'b1;
          eData  = modelMem[(actBase + k) % MW];
          eLast  = (k == BL - 1);
        end
      end
      check("busy",  memBusy,      eBusy);
      check("valid", memDataValid, eValid);
      check("last",  memBurstLast, eLast);
      check("done",  memWriteDone, eDone);
      check("data",  dataFromMem,  eData);
      // Advance to the state after this cycle's closing edge.
      if (rst) begin
        act = 1'b0;
      end else if (act) begin
        if (actWr && cyc == actT + L - 1) modelMem[actIdx] = actData;
        if (cyc == actEnd) act = 1'b0;
      end else if (memoryEnable) begin
        act     = 1'b1;
        actWr   = memWrite;
        actT    = cyc;
        actIdx  = int'(addrToMem) % MW;
        actBase = actIdx - (actIdx % BL);
        actData = dataToMem;
        actEnd  = memWrite ? cyc + L : cyc + L + BL - 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycle(input int c);
    while (cyc < c) step();
  endtask

  task automatic issue(input bit wr, input logic [15:0] a, input logic [15:0] d, output int t);
    memoryEnable = 1'b1;
    memWrite     = wr;
    addrToMem    = a;
    dataToMem    = d;
    t = cyc;
    step();
    memoryEnable = 1'b0;
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [15:0] d);
    int t;
    issue(1'b1, a, d, t);
    waitCycle(t + L + 1);
  endtask

  task automatic doRead(input logic [15:0] a);
    int t;
    issue(1'b0, a, '0, t);
    waitCycle(t + L + BL);
  endtask

  initial begin
    int t;
    int t2;
    logic [15:0] lineVals [4];
    lineVals[0] = 16'hA0A0;
    lineVals[1] = 16'hA1A1;
    lineVals[2] = 16'hA2A2;
    lineVals[3] = 16'hA3A3;

    rst = 1'b1;
    step();
    checkOn = 1'b1;
    step();
    check("rst_busy",  memBusy,      1'b0);
    check("rst_valid", memDataValid, 1'b0);
    check("rst_data",  dataFromMem,  16'h0000);
    check("rst_done",  memWriteDone, 1'b0);

    // Request presented in the cycle reset is released.
    rst = 1'b0;
    issue(1'b1, 16'h0004, 16'h4444, t);
    check("rstfall_accept", memBusy, 1'b1);
    waitCycle(t + L + 1);

    doWrite(16'h0005, 16'h5555);
    doWrite(16'h0006, 16'h6666);
    doWrite(16'h0007, 16'h7777);
    for (int i = 0; i < 4; i++) doWrite(16'h0010 + 16'(i), lineVals[i]);

    // Write 0xBEEF to 0x0005.
    issue(1'b1, 16'h0005, 16'hBEEF, t);
    check("wr_busy_first", memBusy, 1'b1);
    waitCycle(t + 3);
    check("wr_done_early", memWriteDone, 1'b0);
    waitCycle(t + 4);
    check("wr_done", memWriteDone, 1'b1);
    check("wr_busy_last", memBusy, 1'b1);
    waitCycle(t + 5);
    check("wr_idle", memBusy, 1'b0);
    issue(1'b0, 16'h0004, '0, t);
    waitCycle(t + 5);
    check("rd_after_wr", dataFromMem, 16'hBEEF);
    waitCycle(t + L + BL);

    // Read 0x0012 returns line 0x10..0x13.
    issue(1'b0, 16'h0012, '0, t);
    waitCycle(t + 3);
    check("rd_not_yet", memDataValid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      waitCycle(t + 4 + k);
      check("rd_word", dataFromMem, lineVals[k]);
      check("rd_last", memBurstLast, (k == 3) ? 1'b1 : 1'b0);
    end
    waitCycle(t + 8);
    check("rd_idle", memBusy, 1'b0);
    check("rd_idle_data", dataFromMem, 16'h0000);

    // Enable during a read (carrying a write) must be ignored.
    issue(1'b0, 16'h0012, '0, t);
    waitCycle(t + 2);
    memoryEnable = 1'b1;
    memWrite     = 1'b1;
    addrToMem    = 16'h0011;
    dataToMem    = 16'hDEAD;
    step();
    memoryEnable = 1'b0;
    waitCycle(t + 7);
    check("ign_last_word", dataFromMem, 16'hA3A3);
    waitCycle(t + 8);
    check("ign_idle", memBusy, 1'b0);
    doRead(16'h0011);

    // Reset in the middle of a burst.
    issue(1'b0, 16'h0012, '0, t);
    waitCycle(t + 5);
    check("abort_pre", dataFromMem, 16'hA1A1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", memDataValid, 1'b0);
    check("abort_busy",  memBusy, 1'b0);
    check("abort_data",  dataFromMem, 16'h0000);
    waitCycle(t + 10);
    issue(1'b0, 16'h0012, '0, t);
    waitCycle(t + 5);
    check("reread_intact", dataFromMem, 16'hA1A1);
    waitCycle(t + L + BL);

    // Upper address bits wrap.
    doWrite(16'h0405, 16'h1234);
    issue(1'b0, 16'h0005, '0, t);
    waitCycle(t + 5);
    check("wrap_read", dataFromMem, 16'h1234);
    waitCycle(t + L + BL);
    doRead(16'hFC12);

    // Write aborted before its commit edge leaves storage alone.
    issue(1'b1, 16'h0007, 16'hDEAD, t);
    waitCycle(t + 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    waitCycle(t + 6);
    issue(1'b0, 16'h0004, '0, t2);
    waitCycle(t2 + 7);
    check("aborted_wr", dataFromMem, 16'h7777);
    waitCycle(t2 + L + BL);

    // Continuous read requests.
    memoryEnable = 1'b1;
    memWrite     = 1'b0;
    addrToMem    = 16'h0012;
    t = cyc;
    waitCycle(t + 8);
    check("b2b_gap_busy", memBusy, 1'b0);
    check("b2b_gap_data", dataFromMem, 16'h0000);
    waitCycle(t + 9);
    check("b2b_reaccept", memBusy, 1'b1);
    waitCycle(t + 12);
    check("b2b_word0", dataFromMem, 16'hA0A0);
    waitCycle(t + 17);
    memoryEnable = 1'b0;
    waitCycle(t + 16 + L + BL + 1);

    checkOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
